// File: rtl/seq_restoring_div.sv
// Iterative unsigned restoring divider: one quotient bit per cycle from a trial
// subtraction of the divisor from the shifted partial remainder.
module seq_restoring_div #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] div_reg;
  logic [WIDTH:0]   r_reg;

  logic [WIDTH+1:0] r_shift;
  logic [WIDTH+1:0] trial;
  logic             borrow;
  logic [WIDTH:0]   r_next;
  logic [WIDTH-1:0] q_next;

  // The partial remainder never reaches the divisor, so its top bit stays zero and
  // the borrow out of the widened subtraction decides the quotient bit.
  always_comb begin
    r_shift = {r_reg, q_reg[WIDTH-1]};
    trial   = r_shift - {2'b00, div_reg};
    borrow  = trial[WIDTH+1];
    r_next  = borrow ? r_shift[WIDTH:0] : trial[WIDTH:0];
    q_next  = {q_reg[WIDTH-2:0], ~borrow};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      q_reg       <= '0;
      r_reg       <= '0;
      div_reg     <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            div_reg     <= divisor;
            q_reg       <= dividend;
            r_reg       <= '0;
            count       <= CW'(WIDTH);
            div_by_zero <= 1'b0;
            if (divisor == '0) begin
              // Divide by zero skips the iterations and reports saturated results.
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              state       <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          q_reg <= q_next;
          r_reg <= r_next;
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            quotient  <= q_next;
            remainder <= r_next[WIDTH-1:0];
            state     <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state == CALC);
  assign done = (state == DONE);

endmodule

// File: tb/tb_seq_restoring_div.sv
// Directed and exhaustive bench for seq_restoring_div (WIDTH=4) using a queue of
// expected results filled at request time and drained at each done pulse.
module tb_seq_restoring_div;

  localparam int WIDTH = 4;

  typedef struct {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dz;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  seq_restoring_div #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
  endtask

  // Reference model using native integer division and modulo.
  function automatic exp_t model(input int a, input int b);
    exp_t e;
    if (b == 0) begin
      e.q  = '1;
      e.r  = WIDTH'(a);
      e.dz = 1'b1;
    end else begin
      e.q  = WIDTH'(a / b);
      e.r  = WIDTH'(a % b);
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Drives one request through its accepting edge and records the expected result.
  task automatic applyStimulus(input int a, input int b);
    dividend = WIDTH'(a);
    divisor  = WIDTH'(b);
    start    = 1'b1;
    sb.push_back(model(a, b));
    tick();
    start = 1'b0;
  endtask

  // Waits for done, checking latency and busy occupancy on the way.
  task automatic waitDone(input string tag, input int exp_lat, input int exp_busy);
    int cyc = 0;
    int busy_cnt = 0;
    while (done !== 1'b1 && cyc < 20) begin
      if (busy === 1'b1) busy_cnt++;
      tick();
      cyc++;
    end
    check({tag, "_latency"}, cyc, exp_lat);
    check({tag, "_busycycles"}, busy_cnt, exp_busy);
    check({tag, "_busy_at_done"}, {31'b0, busy}, 0);
  endtask

  // Compares the done-cycle results against the oldest expectation, then steps
  // into the following IDLE cycle and confirms done was a single pulse.
  task automatic checkOutput(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      check({tag, "_quotient"}, quotient, e.q);
      check({tag, "_remainder"}, remainder, e.r);
      check({tag, "_div_by_zero"}, {31'b0, div_by_zero}, {31'b0, e.dz});
    end
    tick();
    check({tag, "_done_pulse"}, {31'b0, done}, 0);
  endtask

  initial begin
    int seen_done;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    tick();
    tick();
    check("reset_busy", {31'b0, busy}, 0);
    check("reset_done", {31'b0, done}, 0);
    check("reset_quotient", quotient, 0);
    check("reset_remainder", remainder, 0);
    check("reset_dz", {31'b0, div_by_zero}, 0);
    rst = 1'b0;
    tick();

    $display("[TB] basic and boundary divides");
    applyStimulus(13, 3); waitDone("d13_3", WIDTH, WIDTH); checkOutput("d13_3");
    applyStimulus(15, 1); waitDone("d15_1", WIDTH, WIDTH); checkOutput("d15_1");
    applyStimulus(7, 9);  waitDone("d7_9", WIDTH, WIDTH);  checkOutput("d7_9");
    applyStimulus(15, 15); waitDone("d15_15", WIDTH, WIDTH); checkOutput("d15_15");
    applyStimulus(0, 5);  waitDone("d0_5", WIDTH, WIDTH);  checkOutput("d0_5");

    $display("[TB] divide by zero then recovery");
    applyStimulus(10, 0); waitDone("d10_0", 0, 0); checkOutput("d10_0");
    applyStimulus(6, 2);  waitDone("d6_2", WIDTH, WIDTH); checkOutput("d6_2");

    $display("[TB] start and operand changes while busy");
    applyStimulus(9, 2);
    tick();
    dividend = 4'd15;
    divisor  = 4'd1;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    dividend = 4'd3;
    divisor  = 4'd0;
    waitDone("d9_2_busy", WIDTH - 2, WIDTH - 2);
    checkOutput("d9_2_busy");
    check("ignored_start_no_restart", {31'b0, busy}, 0);

    $display("[TB] reset in the middle of a division");
    applyStimulus(14, 3);
    void'(sb.pop_back());
    tick();
    rst   = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("midrst_busy", {31'b0, busy}, 0);
    check("midrst_done", {31'b0, done}, 0);
    check("midrst_quotient", quotient, 0);
    check("midrst_remainder", remainder, 0);
    rst = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 3 * WIDTH; i++) begin
      if (done === 1'b1 || busy === 1'b1) seen_done = 1;
      tick();
    end
    check("midrst_no_activity", seen_done, 0);
    applyStimulus(14, 3); waitDone("d14_3", WIDTH, WIDTH); checkOutput("d14_3");

    $display("[TB] exhaustive back-to-back sweep");
    for (int a = 0; a < (1 << WIDTH); a++) begin
      for (int b = 0; b < (1 << WIDTH); b++) begin
        applyStimulus(a, b);
        waitDone($sformatf("x%0d_%0d", a, b), (b == 0) ? 0 : WIDTH, (b == 0) ? 0 : WIDTH);
        checkOutput($sformatf("x%0d_%0d", a, b));
      end
    end

    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
